// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative RV32M multiply/divide sequencer with pipeline stall and done pulse.
// Define MDU_DIV_EN to build the divider; otherwise divide ops finish at once and are flagged illegal.
module mdu_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            illegal
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        sa_q, sa_d, sb_q, sb_d;
    logic [31:0] res_q, res_d;
    logic        ill_q, ill_d;
    logic        s1, s2, accept;
    logic [63:0] prod;
    logic [31:0] mul_res, fix_res;

    assign prod    = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign mul_res = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];

`ifdef MDU_DIV_EN
    logic [32:0] r_sh, diff;
    logic [31:0] quo, rem;
    // acc holds {remainder, quotient}; dividend bits are consumed MSB first
    assign r_sh    = {acc_q[63:32], a_q[5'd31 - cnt_q[4:0]]};
    assign diff    = r_sh - {1'b0, b_q};
    assign quo     = (sa_q ^ sb_q) ? -acc_q[31:0] : acc_q[31:0];
    assign rem     = sa_q ? -acc_q[63:32] : acc_q[63:32];
    assign fix_res = op_q[2] ? (op_q[1] ? rem : quo) : mul_res;
`else
    assign fix_res = op_q[2] ? 32'd0 : mul_res;
`endif

    always_comb begin
        s1      = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        s2      = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        accept  = start && (state_q == S_IDLE || state_q == S_DONE);
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        ill_d   = ill_q;
        if (flush) begin
            state_d = S_IDLE;
        end else if (accept) begin
            op_d    = funct3;
            sa_d    = s1 && rs1_val[31];
            sb_d    = s2 && rs2_val[31];
            a_d     = sa_d ? -rs1_val : rs1_val;
            b_d     = sb_d ? -rs2_val : rs2_val;
            acc_d   = '0;
            cnt_d   = '0;
            ill_d   = 1'b0;
            state_d = funct3[2] ? S_DIV : S_MUL;
`ifdef MDU_DIV_EN
            if (funct3[2] && rs2_val == '0) begin
                state_d = S_DONE;
                res_d   = funct3[1] ? rs1_val : '1;
            end else if (funct3[2] && !funct3[0] && rs1_val == 32'h8000_0000 && rs2_val == '1) begin
                state_d = S_DONE;
                res_d   = funct3[1] ? 32'd0 : 32'h8000_0000;
            end
`else
            if (funct3[2]) begin
                state_d = S_DONE;
                res_d   = '0;
                ill_d   = 1'b1;
            end
`endif
        end else if (state_q == S_MUL) begin
            state_d = (cnt_q == 6'd32) ? S_FIX : S_MUL;
            acc_d   = (cnt_q != 6'd32 && b_q[cnt_q[4:0]]) ? acc_q + ({32'd0, a_q} << cnt_q[4:0]) : acc_q;
            cnt_d   = (cnt_q == 6'd32) ? cnt_q : cnt_q + 6'd1;
`ifdef MDU_DIV_EN
        end else if (state_q == S_DIV) begin
            state_d = (cnt_q == 6'd32) ? S_FIX : S_DIV;
            acc_d   = (cnt_q == 6'd32) ? acc_q :
                      {diff[32] ? r_sh[31:0] : diff[31:0], acc_q[30:0], ~diff[32]};
            cnt_d   = (cnt_q == 6'd32) ? cnt_q : cnt_q + 6'd1;
`endif
        end else if (state_q == S_FIX) begin
            res_d   = fix_res;
            state_d = S_DONE;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            res_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            ill_q   <= ill_d;
        end
    end

    assign busy    = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign done    = (state_q == S_DONE);
    assign result  = res_q;
    assign illegal = done && ill_q;
endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle sequencer for RV32M multiply/divide instructions in the execute stage. Accepts one operation at a time, iterates a 32-step shift-add multiplier or restoring divider over operand magnitudes, applies RISC-V sign and special-case rules, and returns a 32-bit result with a one-cycle done pulse. While an operation is in flight it asserts a stall to the pipeline controller, which freezes the front-end and keeps `start` deasserted.

## Interface
- `XLEN`, 32, operand/result width; only 32 supported.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `funct3`  in  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_val`  in  XLEN  dividend / multiplicand.
- `rs2_val`  in  XLEN  divisor / multiplier.
- `flush`  in  1  abort in-flight op (branch mispredict / trap).
- `busy`  out  1  high in MUL, DIV, FIX states; used directly as pipeline stall.
- `done`  out  1  one-cycle pulse; `result` valid that cycle.
- `result`  out  XLEN  registered result; holds until next accepted op.
- `illegal`  out  1  pulses with `done` for unsupported op (see Configuration).

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE/DONE + `start`: latch funct3, operand magnitudes, result-sign flags; clear 6-bit iteration counter; go MUL (funct3[2]=0) or DIV (funct3[2]=1). Exception: special-case divides go straight to DONE.
- Signedness: rs1 signed for MULH, MULHSU, DIV, REM; rs2 signed for MULH, DIV, REM. Magnitude = two's-complement negate if signed and bit 31 set.
- MUL: 64-bit accumulator; each cycle add multiplicand<<i if multiplier bit i set; 32 cycles, then FIX.
- DIV: restoring; each cycle shift remainder left, bring in next dividend bit, subtract divisor, keep if non-negative and set quotient bit; 32 cycles, then FIX.
- FIX: negate product if operand signs differ (signed cases); quotient negated if dividend/divisor signs differ; remainder takes dividend sign. Select low 32 (MUL), high 32 (MULH*), quotient (DIV/DIVU), remainder (REM/REMU). Register into `result`; go DONE.
- DONE: `done`=1 one cycle; next state IDLE, or MUL/DIV/DONE if `start`.
- Special cases (resolved in the accepting cycle, no iteration):
  - divisor 0: quotient 0xFFFFFFFF, remainder = rs1_val.
  - signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0.
- `start` in MUL/DIV/FIX: ignored, no queueing.
- `flush`: any state -> IDLE next edge; `done` not generated; `result` unchanged. Flush and `start` in the same cycle: flush wins, op dropped.
- `rst` overrides `flush` and `start`.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `illegal` 0, `result` 0, counter 0.
- `start` accepted at edge E. Iterative op: MUL/DIV after E through E+32, FIX after E+33, `done`=1 in the cycle after edge E+34 (34-cycle latency). `busy` high in cycles after E..E+33.
- Special-case divide and illegal op: `done` in the cycle after E (1-cycle latency), `busy` never asserted.
- Back-to-back: `start` during DONE accepted with no idle gap.
- Counter stops at 32; no wrap.

## Configuration
- `MDU_DIV_EN` defined: full divide path; `illegal` tied 0.
- `MDU_DIV_EN` undefined: DIV state, divider datapath and divide special cases removed; funct3[2]=1 ops complete with 1-cycle latency, `result`=0, `illegal`=1 with `done`. Multiply behaviour identical in both builds.

## Test plan
- MUL 7 x 0xFFFFFFFD -> `done` exactly 34 cycles after accept, `result`=0xFFFFFFEB; `busy` high 34 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF, REM 5 / 0 -> 5, DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; each `done` 1 cycle after accept, `busy` never high.
- Flush asserted 10 cycles into MUL -> IDLE next cycle, no `done`, `result` unchanged; immediate MULHU 3 x 5 -> 0 after 34 cycles. Repeat with `rst` mid-DIV -> all outputs at reset values.
- Build without `MDU_DIV_EN`: DIVU 9 / 3 -> `done`+`illegal` 1 cycle after accept, `result`=0; MUL 6 x 7 -> 42 unaffected.
